// File: rtl/pc_seq_pkg.sv
// Shared types, default sizing and PC alignment helper for the fetch-stage sequencer.
package pc_seq_pkg;

    localparam int unsigned DEF_PC_W        = 8;
    localparam int unsigned DEF_INSTR_BYTES = 4;
    localparam int unsigned DEF_RESET_PC    = 0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_INC   = 2'd1,
        SEL_REDIR = 2'd2,
        SEL_RESET = 2'd3
    } pc_sel_t;

    // Clear the low address bits so a redirect lands on an instruction boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr, input int unsigned low_bits);
        return addr & ~((32'd1 << low_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: hold, sequential increment, aligned redirect target or reset vector.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int unsigned RESET_PC    = DEF_RESET_PC
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic [1:0]      sel,
    output logic [PC_W-1:0] pc_next
);

    localparam int unsigned LOW_BITS = $clog2(INSTR_BYTES);

    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_INC:   pc_next = pc + PC_W'(INSTR_BYTES);
            SEL_REDIR: pc_next = PC_W'(align_pc(32'(redirect_pc), LOW_BITS));
            SEL_RESET: pc_next = PC_W'(RESET_PC);
            default:   pc_next = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, issues imem requests, buffers a fetch
// across IF/ID stalls and applies EX redirects with a one-cycle flush.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int unsigned RESET_PC    = DEF_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic            flush,
    output logic [PC_W-1:0] pc_out
);

    state_t          state;
    state_t          state_next;
    pc_sel_t         pc_sel;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            emit;
    logic            emit_pend;
    logic            capture;
    logic            do_flush;
    logic [31:0]     pend_instr;
    logic [PC_W-1:0] pend_pc;

    pc_next_mux #(
        .PC_W        (PC_W),
        .INSTR_BYTES (INSTR_BYTES),
        .RESET_PC    (RESET_PC)
    ) u_pc_next_mux (
        .pc          (pc),
        .redirect_pc (redirect_pc),
        .sel         (pc_sel),
        .pc_next     (pc_next)
    );

    // State register; the reset vector reaches pc through the mux.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
        pc <= pc_next;
    end

    // Next state: redirect overrides everything outside reset.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = FETCH;
        end else begin
            case (state)
                BOOT:    state_next = FETCH;
                FETCH:   if (imem_ack && stall) state_next = HOLD;
                HOLD:    if (!stall) state_next = FETCH;
                default: state_next = BOOT;
            endcase
        end
    end

    // Decoded controls and the combinational request outputs.
    always_comb begin
        pc_sel    = SEL_HOLD;
        emit      = 1'b0;
        emit_pend = 1'b0;
        capture   = 1'b0;
        do_flush  = 1'b0;
        imem_req  = (state == FETCH);
        imem_addr = pc;
        if (!reset) begin
            pc_sel = SEL_RESET;
        end else if (redirect_valid) begin
            pc_sel   = SEL_REDIR;
            do_flush = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack && stall) begin
                        capture = 1'b1;
                    end else if (imem_ack) begin
                        emit   = 1'b1;
                        pc_sel = SEL_INC;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        emit      = 1'b1;
                        emit_pend = 1'b1;
                        pc_sel    = SEL_INC;
                    end
                end
                default: pc_sel = SEL_HOLD;
            endcase
        end
    end

    // Registered IF/ID outputs and the stall pending buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if_valid   <= 1'b0;
            flush      <= 1'b0;
            if_instr   <= 32'd0;
            if_pc      <= PC_W'(0);
            pend_instr <= 32'd0;
            pend_pc    <= PC_W'(0);
        end else begin
            if_valid <= emit;
            flush    <= do_flush;
            if (emit) begin
                if_instr <= emit_pend ? pend_instr : imem_rdata;
                if_pc    <= emit_pend ? pend_pc : pc;
            end
            if (do_flush) begin
                pend_instr <= 32'd0;
                pend_pc    <= PC_W'(0);
            end else if (capture) begin
                pend_instr <= imem_rdata;
                pend_pc    <= pc;
            end
        end
    end

    assign pc_out = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: transaction-level fetch model checked every cycle plus directed literal checks.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        flush;
    logic [7:0]  pc_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .flush          (flush),
        .pc_out         (pc_out)
    );

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return 32'hC0DE_0000 | {24'd0, a} | ({24'd0, ~a} << 8);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: a PC, a boot flag and a queue of fetched-but-blocked instructions.
    typedef struct {
        logic [31:0] instr;
        logic [7:0]  pc;
    } ent_t;

    logic [7:0]  m_pc;
    bit          m_boot;
    bit          m_live = 1'b0;
    ent_t        m_pend[$];
    logic        exp_valid;
    logic        exp_flush;
    logic [31:0] exp_instr;
    logic [7:0]  exp_ipc;

    always @(posedge clk) begin
        ent_t e;
        exp_valid = 1'b0;
        exp_flush = 1'b0;
        if (!reset) begin
            m_live = 1'b1;
            m_pc   = 8'h00;
            m_boot = 1'b1;
            m_pend.delete();
        end else if (redirect_valid) begin
            m_pc      = redirect_pc & 8'hFC;
            exp_flush = 1'b1;
            m_boot    = 1'b0;
            m_pend.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_pend.size() != 0) begin
            if (!stall) begin
                e         = m_pend.pop_front();
                exp_valid = 1'b1;
                exp_instr = e.instr;
                exp_ipc   = e.pc;
                m_pc      = m_pc + 8'd4;
            end
        end else if (imem_ack) begin
            if (stall) begin
                e.instr = mem_word(m_pc);
                e.pc    = m_pc;
                m_pend.push_back(e);
            end else begin
                exp_valid = 1'b1;
                exp_instr = mem_word(m_pc);
                exp_ipc   = m_pc;
                m_pc      = m_pc + 8'd4;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("if_valid", 32'(if_valid), 32'(exp_valid));
            chk("flush", 32'(flush), 32'(exp_flush));
            chk("pc_out", 32'(pc_out), 32'(m_pc));
            chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("imem_req", 32'(imem_req), 32'(!m_boot && m_pend.size() == 0));
            if (exp_valid) begin
                chk("if_instr", if_instr, exp_instr);
                chk("if_pc", 32'(if_pc), 32'(exp_ipc));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic s, input logic rv, input logic [7:0] rpc, input logic a);
        reset          = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = a;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        chk("lit_reset_pc", 32'(pc_out), 32'h00);
        chk("lit_reset_req", 32'(imem_req), 32'h0);
        chk("lit_reset_valid", 32'(if_valid), 32'h0);
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("lit_boot_req", 32'(imem_req), 32'h1);
        chk("lit_boot_addr", 32'(imem_addr), 32'h00);
        chk("lit_boot_valid", 32'(if_valid), 32'h0);
        tick();
        chk("lit_run0_pc", 32'(if_pc), 32'h00);
        chk("lit_run0_instr", if_instr, 32'hC0DE_FF00);
        tick();
        chk("lit_run1_pc", 32'(if_pc), 32'h04);

        // Stall on ack at pc 0x08 for three cycles
        set_in(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_hold_valid", 32'(if_valid), 32'h0);
            chk("lit_hold_req", 32'(imem_req), 32'h0);
            chk("lit_hold_pc", 32'(pc_out), 32'h08);
        end
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("lit_unhold_valid", 32'(if_valid), 32'h1);
        chk("lit_unhold_pc", 32'(if_pc), 32'h08);
        chk("lit_unhold_addr", 32'(imem_addr), 32'h0C);

        // No ack while stalled keeps requesting
        set_in(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        chk("lit_noack_req", 32'(imem_req), 32'h1);
        chk("lit_noack_pc", 32'(pc_out), 32'h0C);

        // Redirect with concurrent ack
        set_in(1'b1, 1'b0, 1'b1, 8'h41, 1'b1);
        tick();
        chk("lit_redir_flush", 32'(flush), 32'h1);
        chk("lit_redir_valid", 32'(if_valid), 32'h0);
        chk("lit_redir_addr", 32'(imem_addr), 32'h40);
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("lit_redir_flush_once", 32'(flush), 32'h0);

        // Redirect during HOLD drops the buffered fetch
        set_in(1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        chk("lit_hold10_req", 32'(imem_req), 32'h0);
        set_in(1'b1, 1'b1, 1'b1, 8'h80, 1'b0);
        tick();
        chk("lit_hredir_flush", 32'(flush), 32'h1);
        chk("lit_hredir_addr", 32'(imem_addr), 32'h80);
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("lit_hredir_pc", 32'(if_pc), 32'h80);

        // Wrap past 0xFF
        set_in(1'b1, 1'b0, 1'b1, 8'hF8, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("lit_wrap_f8", 32'(if_pc), 32'hF8);
        tick();
        chk("lit_wrap_fc", 32'(if_pc), 32'hFC);
        tick();
        chk("lit_wrap_00", 32'(if_pc), 32'h00);
        chk("lit_wrap_00_flush", 32'(flush), 32'h0);
        tick();
        chk("lit_wrap_04", 32'(if_pc), 32'h04);

        // Mid-run reset from HOLD
        set_in(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        chk("lit_mreset_pc", 32'(pc_out), 32'h00);
        chk("lit_mreset_req", 32'(imem_req), 32'h0);
        chk("lit_mreset_flush", 32'(flush), 32'h0);
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("lit_mreset_fetch", 32'(imem_req), 32'h1);
        tick();
        chk("lit_mreset_first", 32'(if_pc), 32'h00);

        // Redirect taken from BOOT
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 8'h27, 1'b1);
        tick();
        chk("lit_bredir_flush", 32'(flush), 32'h1);
        chk("lit_bredir_addr", 32'(imem_addr), 32'h24);
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("lit_bredir_pc", 32'(if_pc), 32'h24);

        // Mixed directed pattern, checked by the per-cycle model
        for (int i = 0; i < 300; i++) begin
            set_in(i % 97 != 50, (i % 5 == 2) || (i % 7 == 3), i % 17 == 9,
                   8'(i * 37), i % 3 != 0);
            tick();
        end
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage controller for the 5-stage pipeline. Owns the program counter and sequences instruction-memory requests.
- Holds fetch when the hazard unit stalls, and applies branch/jump redirects from EX.
- Presents fetched instructions to the IF/ID register with a valid strobe and PC tag.
- Sits between the hazard unit, EX branch resolution, instruction memory and IF/ID.

Parameters:
- PC_W, 8, program-counter / instruction-address width in bits.
- INSTR_BYTES, 4, PC increment per sequential fetch.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock; only clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- stall  in  1  hazard unit: IF/ID cannot accept a new instruction this cycle.
- redirect_valid  in  1  EX: taken branch/jump this cycle.
- redirect_pc  in  PC_W  EX: target address.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_W  fetch address; always equals pc_out.
- imem_ack  in  1  memory returns imem_rdata for imem_addr this cycle.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  one-cycle strobe: if_instr/if_pc valid for IF/ID.
- if_instr  out  32  registered instruction.
- if_pc  out  PC_W  PC of if_instr.
- flush  out  1  one-cycle pulse: kill IF/ID and ID/EX contents.
- pc_out  out  PC_W  current PC.

Behaviour:
- Reset (reset=0 at a rising edge):
  - pc=RESET_PC; state=BOOT.
  - imem_req=0, if_valid=0, flush=0, if_instr=0, if_pc=0.
  - Pending buffer cleared.
  - Applies mid-operation; an in-flight ack is dropped.
- States: BOOT, FETCH, HOLD.
- BOOT:
  - imem_req=0.
  - Next cycle goes to FETCH unless a redirect is applied (see the redirect rule).
- FETCH:
  - imem_req=1, imem_addr=pc.
  - ack & !stall: next cycle if_valid=1, if_instr=imem_rdata, if_pc=pc, pc=pc+INSTR_BYTES; stay in FETCH.
  - Back-to-back acks give 1 instr/cycle.
  - ack & stall: capture rdata and pc into the pending buffer; go to HOLD; if_valid=0; pc unchanged.
  - !ack: hold pc and keep imem_req=1, regardless of stall.
- HOLD:
  - imem_req=0.
  - While stall=1: stay in HOLD, if_valid=0.
  - First cycle stall=0: next cycle if_valid=1 with the buffered instr/pc, pc=pc+INSTR_BYTES, state=FETCH.
- Redirect (highest priority, any non-reset state):
  - pc=redirect_pc with low log2(INSTR_BYTES) bits cleared.
  - flush=1 for exactly one cycle; if_valid=0.
  - Pending buffer discarded; state=FETCH.
  - A same-cycle imem_ack is discarded.
  - Redirect while stalled is still taken.
  - Redirect in BOOT is taken.
- Latency:
  - ack at edge N gives if_valid at N+1.
  - Redirect at edge N gives flush at N+1 and imem_addr=target at N+1.
- Arithmetic: pc increment is modulo 2^PC_W; 0xFC+4 wraps to 0x00 with no flag.
- if_valid and flush are never both 1.
- Outputs are registered except imem_req and imem_addr, which are decoded from state/pc.

Decomposition:
- Package pc_seq_pkg holds:
  - state_t enum {BOOT, FETCH, HOLD};
  - default PC_W, INSTR_BYTES, RESET_PC constants;
  - a function aligning a PC (clearing low bits).
- One natural sub-module: pc_next_mux, purely combinational.
  - Selects next pc from {hold, pc+INSTR_BYTES, aligned redirect_pc, RESET_PC}.
  - Select comes from the FSM.

Test Plan:
- Reset then free run: reset=0 for 2 cycles then 1, ack held 1, stall 0 → imem_addr 0x00 (BOOT 1 cycle), then if_valid every cycle with if_pc 0x00,0x04,0x08; flush=0.
- Stall on ack: at pc=0x08, ack=1 with stall=1 for 3 cycles → imem_req=0 in HOLD, if_valid=0 for 3 cycles, pc_out=0x08; cycle after stall drops, if_valid=1, if_pc=0x08, then imem_addr=0x0C.
- Redirect: redirect_valid=1, redirect_pc=0x41 with concurrent ack → flush=1 one cycle, if_valid=0, next imem_addr=0x40, ack data dropped.
- Redirect during HOLD: stall=1 holding pc=0x10, redirect to 0x80 → flush pulse, buffered 0x10 never appears on if_valid, fetch resumes at 0x80.
- Wrap: redirect to 0xF8, ack continuous → if_pc 0xF8, 0xFC, 0x00, 0x04.
- Mid-run reset: reset=0 during a stalled HOLD → next cycle pc_out=0x00, if_valid=0, flush=0, imem_req=0; BOOT then FETCH from 0x00 after release.
